// File: rtl/uart_rx_ctrl_if.sv
// Host-side bundle of the UART receive controller: serial line in, received byte
// and status out, plus the sticky-flag acknowledge.
interface uart_rx_ctrl_if;
    logic       rx;
    logic       rx_flag_clr;
    logic [7:0] Rx_Data;
    logic       rx_flag;
    logic       parity_error;
    logic       framing_error;
    logic       overrun_error;
    logic       busy;

    modport master (
        input  rx,
        input  rx_flag_clr,
        output Rx_Data,
        output rx_flag,
        output parity_error,
        output framing_error,
        output overrun_error,
        output busy
    );

    modport slave (
        output rx,
        output rx_flag_clr,
        input  Rx_Data,
        input  rx_flag,
        input  parity_error,
        input  framing_error,
        input  overrun_error,
        input  busy
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: synchronises rx, validates the start bit at mid-bit,
// samples data/parity/stop at bit centres and posts the byte with sticky status.
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int CW           = 14,
    parameter bit PARITY_EN    = 1'b1
) (
    input  logic           clk,
    input  logic           nrst,
    uart_rx_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [CW-1:0] TICK_C = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_C = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

    logic          sync1_r;
    logic          sync2_r;
    logic          rx_s;
    logic          prev_r;
    state_t        state_r;
    state_t        state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic          par_r;
    logic [7:0]    data_r;
    logic          flag_r;
    logic          pe_r;
    logic          fe_r;
    logic          ovr_r;
    logic          busy_r;
    logic          tick_s;
    logic          half_s;
    logic          done_s;

    assign rx_s   = sync2_r;
    assign tick_s = (cnt_r == TICK_C);
    assign half_s = (cnt_r == HALF_C);

    // Two-flop synchroniser plus previous-sample flop used for falling-edge detection.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= bus.rx;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; IDLE needs a genuine 1->0 edge so a held break cannot restart a frame.
    always_comb begin
        state_nxt_s = state_r;
        done_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (!rx_s && prev_r) begin
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (half_s) begin
                    state_nxt_s = rx_s ? IDLE : DATA;
                end else begin
                    state_nxt_s = START;
                end
            end
            DATA: begin
                if (tick_s && (bit_idx_r == 3'd7)) begin
                    state_nxt_s = (PARITY_EN != 1'b0) ? PARITY : STOP;
                end else begin
                    state_nxt_s = DATA;
                end
            end
            PARITY: begin
                if (tick_s) begin
                    state_nxt_s = STOP;
                end else begin
                    state_nxt_s = PARITY;
                end
            end
            STOP: begin
                if (tick_s) begin
                    state_nxt_s = IDLE;
                    done_s      = 1'b1;
                end else begin
                    state_nxt_s = STOP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Bit-period counter, bit index, data shifter and parity capture.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            par_r     <= 1'b0;
        end else begin
            if ((state_nxt_s != state_r) || tick_s || (state_r == IDLE)) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + ONE_C;
            end
            if (state_r == START) begin
                bit_idx_r <= 3'd0;
            end else if ((state_r == DATA) && tick_s) begin
                bit_idx_r <= bit_idx_r + 3'd1;
            end
            if ((state_r == DATA) && tick_s) begin
                shift_r <= {rx_s, shift_r[7:1]};
            end
            if ((state_r == PARITY) && tick_s) begin
                par_r <= rx_s;
            end
        end
    end

    // Host-visible results; a completion takes priority over a coincident acknowledge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            data_r <= 8'h00;
            flag_r <= 1'b0;
            pe_r   <= 1'b0;
            fe_r   <= 1'b0;
            ovr_r  <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != IDLE);
            if (done_s) begin
                data_r <= shift_r;
                fe_r   <= ~rx_s;
                pe_r   <= (PARITY_EN != 1'b0) && (par_r != even_par(shift_r));
                ovr_r  <= flag_r;
                flag_r <= 1'b1;
            end else if (bus.rx_flag_clr) begin
                flag_r <= 1'b0;
                ovr_r  <= 1'b0;
            end
        end
    end

    assign bus.Rx_Data       = data_r;
    assign bus.rx_flag       = flag_r;
    assign bus.parity_error  = pe_r;
    assign bus.framing_error = fe_r;
    assign bus.overrun_error = ovr_r;
    assign bus.busy          = busy_r;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: bit-level line driver with a scoreboard of expected frames.
module tb_uart_rx_ctrl;
    localparam int CPB = 16;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       ovr;
    } exp_t;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    logic model_flag = 1'b0;
    exp_t sb_q[$];

    uart_rx_ctrl_if bus1();
    uart_rx_ctrl_if bus2();

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .CW(5), .PARITY_EN(1'b1)) u_dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus1.master)
    );

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .CW(5), .PARITY_EN(1'b0)) u_dut_np (
        .clk (clk),
        .nrst(nrst),
        .bus (bus2.master)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one bit period; optionally pulse rx_flag_clr after negedge number clr_at.
    task automatic drive_bit(input logic v, input int clr_at);
        bus1.rx = v;
        for (int i = 0; i < CPB; i++) begin
            @(negedge clk);
            bus1.rx_flag_clr = (i == clr_at) ? 1'b1 : 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int clr_at);
        exp_t e;
        e.data = d;
        e.pe   = par ^ (^d);
        e.fe   = ~stop;
        e.ovr  = model_flag;
        sb_q.push_back(e);
        drive_bit(1'b0, -1);
        for (int i = 0; i < 8; i++) drive_bit(d[i], -1);
        drive_bit(par, -1);
        drive_bit(stop, clr_at);
        bus1.rx = 1'b1;
        model_flag = 1'b1;
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        bus1.rx_flag_clr = 1'b1;
        @(negedge clk);
        bus1.rx_flag_clr = 1'b0;
        model_flag = 1'b0;
    endtask

    // Pop the oldest expected frame and compare it to the DUT outputs.
    task automatic sb_pop_compare(input string name);
        exp_t e;
        for (int i = 0; (i < 40) && (bus1.rx_flag !== 1'b1); i++) @(negedge clk);
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL %s scoreboard empty got=0 exp=1 entries", name);
            return;
        end
        e = sb_q.pop_front();
        if (bus1.rx_flag !== 1'b1) begin bad++; $display("FAIL %s rx_flag got=%b exp=1", name, bus1.rx_flag); end
        total++;
        if (bus1.Rx_Data !== e.data) begin bad++; $display("FAIL %s Rx_Data got=%h exp=%h", name, bus1.Rx_Data, e.data); end
        total++;
        if (bus1.parity_error !== e.pe) begin bad++; $display("FAIL %s parity_error got=%b exp=%b", name, bus1.parity_error, e.pe); end
        total++;
        if (bus1.framing_error !== e.fe) begin bad++; $display("FAIL %s framing_error got=%b exp=%b", name, bus1.framing_error, e.fe); end
        total++;
        if (bus1.overrun_error !== e.ovr) begin bad++; $display("FAIL %s overrun_error got=%b exp=%b", name, bus1.overrun_error, e.ovr); end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus1.Rx_Data, bus1.rx_flag, bus1.parity_error, bus1.framing_error, bus1.overrun_error, bus1.busy} !== 13'h0) begin
            bad++;
            $display("FAIL reset outputs got=%h/%b%b%b%b%b exp=00/00000", bus1.Rx_Data, bus1.rx_flag,
                     bus1.parity_error, bus1.framing_error, bus1.overrun_error, bus1.busy);
        end
        total++;
        if ({bus2.Rx_Data, bus2.rx_flag, bus2.busy} !== 10'h0) begin
            bad++;
            $display("FAIL reset_np outputs got=%h/%b%b exp=00/00", bus2.Rx_Data, bus2.rx_flag, bus2.busy);
        end
        nrst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b0, 1'b1, -1);
        sb_pop_compare("basic_a5");
        total++;
        if (bus1.busy !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b exp=0", bus1.busy); end
    endtask

    task automatic test_parity();
        clr_pulse();
        send_frame(8'h01, 1'b0, 1'b1, -1);
        sb_pop_compare("parity_bad_01");
        clr_pulse();
        send_frame(8'h03, 1'b0, 1'b1, -1);
        sb_pop_compare("parity_ok_03");
    endtask

    task automatic test_framing();
        clr_pulse();
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        sb_pop_compare("framing_3c");
        repeat (20) @(negedge clk);
        clr_pulse();
        send_frame(8'h55, 1'b0, 1'b1, -1);
        sb_pop_compare("framing_ok_55");
    endtask

    task automatic test_break();
        exp_t e;
        clr_pulse();
        e.data = 8'h00; e.pe = 1'b0; e.fe = 1'b1; e.ovr = model_flag;
        sb_q.push_back(e);
        bus1.rx = 1'b0;
        repeat (190) @(negedge clk);
        total++;
        if (bus1.busy !== 1'b0) begin bad++; $display("FAIL break_no_restart busy got=%b exp=0", bus1.busy); end
        repeat (2) @(negedge clk);
        bus1.rx = 1'b1;
        model_flag = 1'b1;
        sb_pop_compare("break");
        repeat (3 * CPB) @(negedge clk);
        total++;
        if (bus1.busy !== 1'b0) begin bad++; $display("FAIL break_idle busy got=%b exp=0", bus1.busy); end
    endtask

    task automatic test_glitch();
        clr_pulse();
        repeat (4) @(negedge clk);
        bus1.rx = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (bus1.busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_high got=%b exp=1", bus1.busy); end
        @(negedge clk);
        bus1.rx = 1'b1;
        repeat (20) @(negedge clk);
        total++;
        if (bus1.busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_low got=%b exp=0", bus1.busy); end
        total++;
        if (bus1.rx_flag !== 1'b0) begin bad++; $display("FAIL glitch_flag got=%b exp=0", bus1.rx_flag); end
    endtask

    task automatic test_back_to_back();
        clr_pulse();
        send_frame(8'h11, 1'b0, 1'b1, -1);
        sb_pop_compare("b2b_11");
        send_frame(8'h22, 1'b0, 1'b1, -1);
        sb_pop_compare("b2b_22_overrun");
        clr_pulse();
        total++;
        if ({bus1.rx_flag, bus1.overrun_error} !== 2'b00) begin
            bad++;
            $display("FAIL b2b_clear flag/ovr got=%b%b exp=00", bus1.rx_flag, bus1.overrun_error);
        end
        total++;
        if (bus1.Rx_Data !== 8'h22) begin bad++; $display("FAIL b2b_hold Rx_Data got=%h exp=22", bus1.Rx_Data); end
        send_frame(8'h33, 1'b0, 1'b1, -1);
        sb_pop_compare("b2b_33");
        send_frame(8'h44, 1'b0, 1'b1, 9);
        sb_pop_compare("clr_at_completion_44");
    endtask

    task automatic test_reset_midframe();
        clr_pulse();
        drive_bit(1'b0, -1);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, -1);
        nrst = 1'b0;
        bus1.rx = 1'b1;
        sb_q.delete();
        model_flag = 1'b0;
        @(negedge clk);
        total++;
        if ({bus1.busy, bus1.rx_flag, bus1.Rx_Data} !== 10'h0) begin
            bad++;
            $display("FAIL abort_reset busy/flag/data got=%b%b/%h exp=00/00", bus1.busy, bus1.rx_flag, bus1.Rx_Data);
        end
        @(negedge clk);
        nrst = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        total++;
        if ({bus1.busy, bus1.rx_flag} !== 2'b00) begin
            bad++;
            $display("FAIL abort_no_flag busy/flag got=%b%b exp=00", bus1.busy, bus1.rx_flag);
        end
        send_frame(8'h0F, 1'b0, 1'b1, -1);
        sb_pop_compare("after_abort_0f");
    endtask

    task automatic test_no_parity();
        logic [9:0] bits;
        bits = {1'b1, 8'h0F, 1'b0};
        for (int b = 0; b < 10; b++) begin
            bus2.rx = bits[b];
            repeat (CPB) @(negedge clk);
        end
        bus2.rx = 1'b1;
        for (int i = 0; (i < 40) && (bus2.rx_flag !== 1'b1); i++) @(negedge clk);
        total++;
        if (bus2.rx_flag !== 1'b1) begin bad++; $display("FAIL np_flag got=%b exp=1", bus2.rx_flag); end
        total++;
        if (bus2.Rx_Data !== 8'h0F) begin bad++; $display("FAIL np_data got=%h exp=0f", bus2.Rx_Data); end
        total++;
        if ({bus2.parity_error, bus2.framing_error} !== 2'b00) begin
            bad++;
            $display("FAIL np_errors pe/fe got=%b%b exp=00", bus2.parity_error, bus2.framing_error);
        end
        total++;
        if (bus2.busy !== 1'b0) begin bad++; $display("FAIL np_busy got=%b exp=0", bus2.busy); end
    endtask

    initial begin
        bus1.rx          = 1'b1;
        bus1.rx_flag_clr = 1'b0;
        bus2.rx          = 1'b1;
        bus2.rx_flag_clr = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_parity();
        test_framing();
        test_break();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
        test_no_parity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
